// File: rtl/board_sprite_loader.sv
// Double-buffered 68x12 board sprite store: a packed nibble stream fills the hidden bank,
// frame_sync swaps it to the front, and the front bank is read combinationally like a ROM.
module board_sprite_loader #(
  parameter int unsigned SPR_W = 68,
  parameter int unsigned SPR_H = 12,
  parameter int unsigned DEPTH = SPR_W * SPR_H
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        frame_sync,
  input  logic [9:0]  read_address,
  output logic [23:0] color_output,
  output logic        busy,
  output logic        done
);

  localparam int unsigned Bytes = DEPTH / 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPending
  } state_e;

  state_e      state;
  logic        front_sel;
  logic [10:0] wr_ptr;
  logic        accept;

  // Each entry holds one byte: [7:4] is the even pixel, [3:0] the odd pixel.
  logic [7:0] bank0 [Bytes];
  logic [7:0] bank1 [Bytes];

  // start takes priority over a coincident handshake, so that byte is dropped.
  assign accept = in_valid && in_ready && !start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      front_sel <= 1'b0;
      wr_ptr    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= StLoad;
        wr_ptr   <= '0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (state)
          StLoad: begin
            if (accept) begin
              wr_ptr <= wr_ptr + 11'd2;
              if (wr_ptr == 11'(DEPTH - 2)) begin
                state    <= StPending;
                in_ready <= 1'b0;
              end
            end
          end
          StPending: begin
            if (frame_sync) begin
              front_sel <= ~front_sel;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Writes always land in the bank that is not being displayed.
  always_ff @(posedge Clk) begin
    if (accept) begin
      if (front_sel) begin
        bank0[wr_ptr[9:1]] <= in_data;
      end else begin
        bank1[wr_ptr[9:1]] <= in_data;
      end
    end
  end

  logic [7:0] rd_byte;
  logic [3:0] rd_idx;

  always_comb begin
    rd_byte      = 8'h00;
    rd_idx       = 4'h0;
    color_output = 24'h000000;
    if (32'(read_address) < DEPTH) begin
      rd_byte = front_sel ? bank1[read_address[9:1]] : bank0[read_address[9:1]];
      rd_idx  = read_address[0] ? rd_byte[3:0] : rd_byte[7:4];
      case (rd_idx)
        4'd0:    color_output = 24'h9a12a2;
        4'd2:    color_output = 24'hdcdcd9;
        default: color_output = 24'h000000;
      endcase
    end
  end

endmodule

// File: tb/tb_board_sprite_loader.sv
// Randomised scoreboard bench for board_sprite_loader: the driver pushes expectations from an
// image-level model, and a negedge monitor pops and compares them against the DUT outputs.
module tb_board_sprite_loader;

  localparam int Depth = 816;
  localparam int Bytes = Depth / 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        frame_sync;
  logic [9:0]  read_address;
  logic [23:0] color_output;
  logic        busy;
  logic        done;

  board_sprite_loader dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .frame_sync  (frame_sync),
    .read_address(read_address),
    .color_output(color_output),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  typedef enum int {KColor, KReady, KBusy, KDone, KHs} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   hs_seen = 0;

  // Reference: two images of palette indices, which one is shown, and load progress.
  logic [3:0] img [2][Depth];
  int front     = 0;
  bit loading   = 0;
  bit pending   = 0;
  bit done_exp  = 0;
  int cnt       = 0;
  int hs_exp    = 0;

  function automatic logic [23:0] pal(input logic [3:0] i);
    if (i == 4'd0) return 24'h9a12a2;
    if (i == 4'd2) return 24'hdcdcd9;
    return 24'h000000;
  endfunction

  function automatic logic [23:0] ref_color(input int a);
    if (a >= Depth) return 24'h000000;
    return pal(img[front][a]);
  endfunction

  task automatic expect_val(input kind_e k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  // Present inputs for one clock, expect the current status, then advance the model.
  task automatic cycle(input bit st, input bit v, input logic [7:0] d, input bit fs);
    start      = st;
    in_valid   = v;
    in_data    = d;
    frame_sync = fs;
    expect_val(KReady, 32'(loading));
    expect_val(KBusy, 32'(loading || pending));
    expect_val(KDone, 32'(done_exp));
    @(posedge Clk);
    #1;
    done_exp = 0;
    if (loading && v) hs_exp++;
    if (st) begin
      loading = 1;
      pending = 0;
      cnt     = 0;
    end else if (loading && v) begin
      img[1-front][2*cnt]   = d[7:4];
      img[1-front][2*cnt+1] = d[3:0];
      cnt++;
      if (cnt == Bytes) begin
        loading = 0;
        pending = 1;
      end
    end else if (pending && fs) begin
      front    = 1 - front;
      pending  = 0;
      done_exp = 1;
    end
  endtask

  task automatic send(input int n, input int mode, input logic [7:0] c);
    int k;
    bit v;
    logic [7:0] d;
    k = 0;
    while (k < n) begin
      v = ($urandom_range(0, 3) != 0);
      case (mode)
        0:       d = {cnt[3:0], ~cnt[3:0]};
        1:       d = c;
        default: d = 8'($urandom);
      endcase
      cycle(1'b0, v, d, 1'b0);
      if (v) k++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic rd(input int a);
    read_address = 10'(a);
    expect_val(KColor, 32'(ref_color(a)));
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd_const(input int a, input logic [23:0] v);
    read_address = 10'(a);
    expect_val(KColor, 32'(v));
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd_rand(input int n);
    for (int i = 0; i < n; i++) rd($urandom_range(0, Depth - 1));
  endtask

  task automatic do_reset();
    start      = 0;
    in_valid   = 0;
    frame_sync = 0;
    Reset      = 1;
    loading    = 0;
    pending    = 0;
    cnt        = 0;
    done_exp   = 0;
    front      = 0;
    expect_val(KReady, 32'd0);
    expect_val(KBusy, 32'd0);
    expect_val(KDone, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 0;
  endtask

  always @(negedge Clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        KColor:  act = {8'h00, color_output};
        KReady:  act = {31'd0, in_ready};
        KBusy:   act = {31'd0, busy};
        KDone:   act = {31'd0, done};
        default: act = 32'(hs_seen);
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", e.kind.name(), $time, act, e.exp);
      end
    end
    if (!Reset && in_valid && in_ready) hs_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < Depth; a++) img[b][a] = 4'h0;
    Reset        = 1;
    start        = 0;
    in_valid     = 0;
    in_data      = 8'h00;
    frame_sync   = 0;
    read_address = 10'd0;
    do_reset();

    // Full load of the counting pattern, then swap.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(Bytes, 0, 8'h00);
    idle(3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done after swap @%0t: got %b, expected 1", $time, done);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy after swap @%0t: got %b, expected 0", $time, busy);
    end
    read_address = 10'd0;
    #1;
    n_chk++;
    if (color_output !== 24'h9a12a2) begin
      n_fail++;
      $display("FAIL colour 0 after swap @%0t: got 0x%0h, expected 0x9a12a2", $time,
               color_output);
    end
    rd_const(0, 24'h9a12a2);
    rd_const(3, 24'h000000);
    rd_rand(20);

    // Back bank writes stay invisible until the swap.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(200, 1, 8'h22);
    rd_const(10, 24'h000000);
    rd(10);
    send(Bytes - 200, 1, 8'h22);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    rd_const(10, 24'hdcdcd9);
    rd_rand(10);

    // Abort and restart.
    hs0 = hs_exp;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(100, 2, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(Bytes, 1, 8'h11);
    expect_val(KHs, 32'(hs0 + 508));
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (hs_seen !== hs0 + 508) begin
      n_fail++;
      $display("FAIL handshakes after abort @%0t: got %0d, expected %0d", $time, hs_seen,
               hs0 + 508);
    end
    for (int a = 0; a < Depth; a++) rd_const(a, 24'h000000);

    // frame_sync during a load, and on the edge of the last byte, must not commit.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(100, 2, 8'h00);
    cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
    send(Bytes - 102, 2, 8'h00);
    cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
    idle(4);
    rd_const(7, 24'h000000);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    rd_rand(10);

    // Async reset part-way through a load.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(50, 2, 8'h00);
    do_reset();
    n_chk++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after reset @%0t: got in_ready=%b busy=%b, expected 0 0", $time,
               in_ready, busy);
    end
    rd_rand(10);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(Bytes, 2, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    rd_rand(20);

    // start colliding with a handshake, then address boundaries.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    send(5, 2, 8'h00);
    cycle(1'b1, 1'b1, 8'hff, 1'b0);
    send(Bytes, 2, 8'h00);
    idle(3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    rd(815);
    rd(814);
    rd_const(816, 24'h000000);
    rd_const(1023, 24'h000000);
    idle(5);
    expect_val(KHs, 32'(hs_exp));
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
